dcpu16_fsl: RTL
===============

# dcpu16_fsl

Fetch-bus responder for the DCPU16 core. It is the memory-side slave that answers the instruction-fetch requests the control unit consumes through `f_dti`/`f_ack`. The block wraps a synchronous word-addressed RAM with a programmable number of wait states and a three-state handshake FSM. Out-of-range fetches return the NOP encoding so the pipeline never stalls on a bad address.

## Interface
- `AW`, 10: word-address width of the internal RAM; depth is 2^AW words of 16 bits.
- `WAIT`, 0: wait states inserted before each access completes; legal range 0..7.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-low.
- `ena`  in  1: global enable. When low, all state is frozen and outputs are held.
- `f_adr`  in  16: word address, sampled with `f_stb`.
- `f_stb`  in  1: request strobe. Held high by the initiator until `f_ack`.
- `f_wre`  in  1: 1 = write, 0 = read; sampled with `f_stb`.
- `f_dto`  in  16: write data, sampled with `f_stb`.
- `f_dti`  out  16: read data, valid while `f_ack`=1.
- `f_ack`  out  1: one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE (reset state).
  - BUSY (counting wait states, then committing the access).
  - ACK (handshake completion).
- IDLE:
  - If `f_stb`=1, latch `f_adr`, `f_wre` and `f_dto` into internal registers.
  - Load the wait counter with `WAIT` and go to BUSY.
  - If `f_stb`=0, stay in IDLE.
- BUSY:
  - If counter ≠ 0, decrement it and stay in BUSY.
  - If counter = 0, commit the access, set `f_ack`<=1 and go to ACK.
- Commit, read: if latched address[15:AW] = 0, `f_dti` <= RAM[address[AW-1:0]]; otherwise `f_dti` <= 16'h0001 (NOP).
- Commit, write: if in range, RAM[address[AW-1:0]] <= latched data; otherwise the write is dropped but still acknowledged. `f_dti` is unchanged on writes.
- ACK: `f_ack` <= 0 and go to IDLE. `f_stb` is ignored in ACK, because the initiator is still releasing the current request.
- The bus inputs are sampled only in IDLE. Changes to `f_adr`, `f_wre` or `f_dto` during BUSY or ACK have no effect.
- `f_dti` holds its last read value between accesses.
- Read-after-write to the same address returns the new data.
- `ena`=0: the FSM, counter, latches, RAM writes and both outputs are held. If `ena` drops while `f_ack`=1, `f_ack` stays high until `ena` returns and the ACK state is exited.
- Reset, asserted at any time:
  - State returns to IDLE.
  - `f_ack`=0, `f_dti`=16'h0000, counter=0.
  - A pending uncommitted write is discarded.
  - RAM contents are not cleared.
- Counter width: 3 bits. No wrap-around is possible, because the counter is loaded only in IDLE and stops at 0.

## Timing
- Reset values: `f_ack`=0 and `f_dti`=16'h0000, asserted asynchronously on `rst` low. Release is synchronous to the next `clk` edge.
- Request sampled at edge E (IDLE, `f_stb`=1).
  - `f_ack` and `f_dti` update at edge E+1+WAIT.
  - Both are visible for exactly one cycle, and `f_ack` clears at edge E+2+WAIT.
- Minimum spacing between samples: the next request is sampled no earlier than edge E+3+WAIT. Peak throughput is one access per WAIT+3 cycles.
- With `WAIT`=0, `f_ack` rises one cycle after the request is sampled.
- The RAM read is synchronous; no combinational path runs from `f_adr` to `f_dti`.
- `f_ack` is registered, with no combinational path from `f_stb`.

## Test plan
- Reset with `f_stb` held high during `rst` low: `f_ack`=0 and `f_dti`=0 throughout. After release, the first request is sampled at the first edge and acked at the next edge (`WAIT`=0).
- `WAIT`=0:
  - Write 16'hBEEF to address 16'h0005; ack arrives at E+1 and `f_dti` is unchanged.
  - Then read 16'h0005; `f_dti`=16'hBEEF with `f_ack` at E+1, high for one cycle.
- `WAIT`=3: read address 0 pre-written with 16'h7C01; `f_ack` rises exactly at E+4, lasts one cycle, and `f_dti`=16'h7C01.
- Out of range (`AW`=10):
  - Read 16'h0400 returns 16'h0001 with ack.
  - Write 16'h1234 to 16'h0400 is acked, and a following read of 16'h0000 still returns its prior contents.
- Hold `f_stb` high across ACK: exactly one ack per request, and the next sample occurs at E+3+WAIT.
- `ena` low for 2 cycles mid-BUSY (`WAIT`=2) delays `f_ack` by exactly 2 cycles.
- Asynchronous `rst` pulse mid-BUSY on a write: no ack, and the address keeps its old data.

Source files
------------

// File: rtl/dcpu16_fsl_if.sv
// Instruction-fetch bus between the DCPU16 control unit (master) and the
// memory-side responder (slave).
interface dcpu16_fsl_if;
  logic [15:0] f_adr;
  logic        f_stb;
  logic        f_wre;
  logic [15:0] f_dto;
  logic [15:0] f_dti;
  logic        f_ack;

  modport master (output f_adr, f_stb, f_wre, f_dto, input f_dti, f_ack);
  modport slave  (input f_adr, f_stb, f_wre, f_dto, output f_dti, f_ack);
endinterface

// File: rtl/dcpu16_fsl.sv
// Fetch-bus responder: word-addressed synchronous RAM behind a
// three-state handshake with programmable wait states.
//
// state | meaning
// IDLE  | waiting for f_stb; latches the request when it arrives
// BUSY  | counting down wait states, commits the access at zero
// ACK   | f_ack high for one cycle; f_stb ignored while it is released
module dcpu16_fsl #(
  parameter int AW   = 10,
  parameter int WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  dcpu16_fsl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2} state_t;

  localparam logic [2:0] WAIT_LD = 3'(WAIT);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [15:0]   adr_q, dto_q, dti_q;
  logic          wre_q, ack_q, ack_d;
  logic          latch, commit, in_range;
  logic [AW-1:0] idx;
  logic [15:0]   ram [2**AW];

  assign idx      = adr_q[AW-1:0];
  assign in_range = (adr_q >> AW) == 16'd0;

  assign bus.f_dti = dti_q;
  assign bus.f_ack = ack_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    latch   = 1'b0;
    commit  = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE: if (bus.f_stb) begin
          latch   = 1'b1;
          cnt_d   = WAIT_LD;
          state_d = BUSY;
        end
        BUSY: if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          commit  = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end
        ACK: begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      ack_q   <= 1'b0;
      dti_q   <= 16'h0000;
      adr_q   <= 16'h0000;
      dto_q   <= 16'h0000;
      wre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      if (latch) begin
        adr_q <= bus.f_adr;
        wre_q <= bus.f_wre;
        dto_q <= bus.f_dto;
      end
      // Out-of-range reads return NOP so the pipeline never stalls.
      if (commit && !wre_q)
        dti_q <= in_range ? ram[idx] : 16'h0001;
    end
  end

  // Contents survive reset; a write only lands on commit, so a reset
  // during BUSY discards it.
  always_ff @(posedge clk) begin
    if (commit && wre_q && in_range)
      ram[idx] <= dto_q;
  end
endmodule
